// File: rtl/mem_access_unit.sv
// MEM-stage initiator for a byte-wide data memory: byte/halfword loads and stores with wait states.
// Optional MAU_ALIGN_CHECK_EN: odd-address halfwords are rejected with a misaligned response.
module mem_access_unit #(
    parameter int unsigned ADDRESS_LINE = 8,
    parameter int unsigned WAIT_STATES  = 0
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    req_valid,
    input  logic                    req_write,
    input  logic                    req_half,
    input  logic                    req_signed,
    input  logic [ADDRESS_LINE-1:0] req_addr,
    input  logic [15:0]             req_wdata,
    output logic                    stall,
    output logic                    resp_valid,
    output logic [15:0]             load_data,
    output logic                    misaligned,
    output logic [ADDRESS_LINE-1:0] mem_address,
    output logic                    mem_read,
    output logic                    mem_write,
    output logic [7:0]              mem_write_data,
    input  logic [7:0]              mem_read_data
);

    localparam int unsigned WCW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;

    typedef enum logic [1:0] {IDLE, BYTE0, BYTE1, DONE} state_e;

    state_e                  state_q, state_d;
    logic [WCW-1:0]          wait_q, wait_d;
    logic                    write_q, write_d;
    logic                    half_q, half_d;
    logic                    signed_q, signed_d;
    logic [ADDRESS_LINE-1:0] addr_q, addr_d;
    logic [15:0]             wdata_q, wdata_d;
    logic [7:0]              lo_q, lo_d;
    logic [15:0]             load_data_q, load_data_d;
    logic                    resp_valid_q, resp_valid_d;
    logic                    misaligned_q, misaligned_d;
    logic                    mem_read_q, mem_read_d;
    logic                    mem_write_q, mem_write_d;
    logic [ADDRESS_LINE-1:0] mem_address_q, mem_address_d;
    logic [7:0]              mem_write_data_q, mem_write_data_d;
    logic                    wait_last;

    assign wait_last = (wait_q == WCW'(WAIT_STATES));

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q          <= IDLE;
            wait_q           <= '0;
            write_q          <= 1'b0;
            half_q           <= 1'b0;
            signed_q         <= 1'b0;
            addr_q           <= '0;
            wdata_q          <= '0;
            lo_q             <= '0;
            load_data_q      <= '0;
            resp_valid_q     <= 1'b0;
            misaligned_q     <= 1'b0;
            mem_read_q       <= 1'b0;
            mem_write_q      <= 1'b0;
            mem_address_q    <= '0;
            mem_write_data_q <= '0;
        end else begin
            state_q          <= state_d;
            wait_q           <= wait_d;
            write_q          <= write_d;
            half_q           <= half_d;
            signed_q         <= signed_d;
            addr_q           <= addr_d;
            wdata_q          <= wdata_d;
            lo_q             <= lo_d;
            load_data_q      <= load_data_d;
            resp_valid_q     <= resp_valid_d;
            misaligned_q     <= misaligned_d;
            mem_read_q       <= mem_read_d;
            mem_write_q      <= mem_write_d;
            mem_address_q    <= mem_address_d;
            mem_write_data_q <= mem_write_data_d;
        end
    end

    // Next state; memory-side outputs are registered from the next-state view of the FSM
    always_comb begin
        state_d      = state_q;
        wait_d       = wait_q;
        write_d      = write_q;
        half_d       = half_q;
        signed_d     = signed_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        lo_d         = lo_q;
        load_data_d  = load_data_q;
        misaligned_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    write_d  = req_write;
                    half_d   = req_half;
                    signed_d = req_signed;
                    addr_d   = req_addr;
                    wdata_d  = req_wdata;
                    wait_d   = '0;
                    state_d  = BYTE0;
`ifdef MAU_ALIGN_CHECK_EN
                    if (req_half && req_addr[0]) begin
                        state_d      = DONE;
                        misaligned_d = 1'b1;
                        load_data_d  = '0;
                    end
`endif
                end
            end
            BYTE0: begin
                if (wait_last) begin
                    wait_d = '0;
                    if (half_q) begin
                        lo_d    = mem_read_data;
                        state_d = BYTE1;
                    end else begin
                        load_data_d = write_q ? 16'h0000
                                    : {{8{mem_read_data[7] & signed_q}}, mem_read_data};
                        state_d     = DONE;
                    end
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            BYTE1: begin
                if (wait_last) begin
                    wait_d      = '0;
                    load_data_d = write_q ? 16'h0000 : {mem_read_data, lo_q};
                    state_d     = DONE;
                end else begin
                    wait_d = wait_q + WCW'(1);
                end
            end
            DONE: begin
                state_d = IDLE;
            end
        endcase

        resp_valid_d     = (state_d == DONE);
        mem_read_d       = ((state_d == BYTE0) || (state_d == BYTE1)) && !write_d;
        mem_write_d      = ((state_d == BYTE0) || (state_d == BYTE1)) && write_d;
        mem_address_d    = '0;
        mem_write_data_d = '0;
        if (state_d == BYTE0) begin
            mem_address_d    = addr_d;
            mem_write_data_d = write_d ? wdata_d[7:0] : 8'h00;
        end else if (state_d == BYTE1) begin
            mem_address_d    = addr_d + ADDRESS_LINE'(1);
            mem_write_data_d = write_d ? wdata_d[15:8] : 8'h00;
        end
    end

    assign stall          = ((state_q == IDLE) && req_valid) || (state_q == BYTE0) || (state_q == BYTE1);
    assign resp_valid     = resp_valid_q;
    assign load_data      = load_data_q;
    assign misaligned     = misaligned_q;
    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_address    = mem_address_q;
    assign mem_write_data = mem_write_data_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Randomized self-checking bench: one DUT with WAIT_STATES=0 and one with WAIT_STATES=2,
// each attached to its own byte memory and compared against a byte-array reference model.
module tb_mem_access_unit;

    logic        clock = 1'b0;
    logic        reset;
    logic [1:0]  req_valid, req_write, req_half, req_signed;
    logic [7:0]  req_addr [2];
    logic [15:0] req_wdata [2];
    logic [1:0]  stall, resp_valid, misaligned, mem_read, mem_write;
    logic [15:0] load_data [2];
    logic [7:0]  mem_address [2];
    logic [7:0]  mem_write_data [2];
    logic [7:0]  mem_read_data [2];

    logic [7:0]  mem [2][256];
    logic [7:0]  ref_mem [2][256];

    int total = 0;
    int bad   = 0;

    always #5 clock = ~clock;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        mem_access_unit #(.ADDRESS_LINE(8), .WAIT_STATES(2 * g)) u_dut (
            .clock          (clock),
            .reset          (reset),
            .req_valid      (req_valid[g]),
            .req_write      (req_write[g]),
            .req_half       (req_half[g]),
            .req_signed     (req_signed[g]),
            .req_addr       (req_addr[g]),
            .req_wdata      (req_wdata[g]),
            .stall          (stall[g]),
            .resp_valid     (resp_valid[g]),
            .load_data      (load_data[g]),
            .misaligned     (misaligned[g]),
            .mem_address    (mem_address[g]),
            .mem_read       (mem_read[g]),
            .mem_write      (mem_write[g]),
            .mem_write_data (mem_write_data[g]),
            .mem_read_data  (mem_read_data[g])
        );
    end

    // Byte-wide data memory: synchronous write, combinational read
    always @(posedge clock) begin
        for (int g = 0; g < 2; g++)
            if (mem_write[g]) mem[g][mem_address[g]] <= mem_write_data[g];
    end

    always_comb begin
        for (int g = 0; g < 2; g++) mem_read_data[g] = mem[g][mem_address[g]];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic set_byte(input int i, input logic [7:0] a, input logic [7:0] v);
        mem[i][a]     <= v;
        ref_mem[i][a]  = v;
    endtask

    // One complete request/response, checked cycle by cycle against the reference rules
    task automatic access(input int i, input bit w, input bit h, input bit s,
                          input logic [7:0] a, input logic [15:0] wd, output logic [15:0] got);
        int          ws = 2 * i;
        int          n  = 0;
        int          k;
        int          b;
        bit          mis = 1'b0;
        logic [7:0]  a1 = a + 8'd1;
        logic [7:0]  lo, hi;
        logic [15:0] exp_ld;
`ifdef MAU_ALIGN_CHECK_EN
        mis = h && a[0];
`endif
        k      = mis ? 1 : 1 + (ws + 1) * (h ? 2 : 1);
        lo     = ref_mem[i][a];
        hi     = ref_mem[i][a1];
        exp_ld = (w || mis) ? 16'h0000 : (h ? {hi, lo} : {{8{lo[7] & s}}, lo});

        req_write[i]  = w;
        req_half[i]   = h;
        req_signed[i] = s;
        req_addr[i]   = a;
        req_wdata[i]  = wd;
        req_valid[i]  = 1'b1;
        #1 check("stall_req", 32'(stall[i]), 32'd1);
        while (n < 20) begin
            @(negedge clock);
            n++;
            if (resp_valid[i]) break;
            b = (n - 1) / (ws + 1);
            check("bus",
                  {19'd0, stall[i], mem_read[i], mem_write[i], mem_address[i], w ? mem_write_data[i] : 8'h00},
                  {19'd0, 1'b1, !w, w, (b != 0) ? a1 : a, w ? ((b != 0) ? wd[15:8] : wd[7:0]) : 8'h00});
        end
        check("latency", 32'(n), 32'(k));
        check("load_data", 32'(load_data[i]), 32'(exp_ld));
        check("misaligned", 32'(misaligned[i]), 32'(mis));
        if (w && !mis) begin
            ref_mem[i][a] = wd[7:0];
            if (h) ref_mem[i][a1] = wd[15:8];
        end
        got          = load_data[i];
        req_valid[i] = 1'b0;
        @(negedge clock);
        check("post_idle", {28'd0, resp_valid[i], stall[i], mem_read[i], mem_write[i]}, 32'd0);
        check("load_hold", 32'(load_data[i]), 32'(exp_ld));
    endtask

    initial begin
        logic [15:0] got;
        logic [7:0]  keep9;
        int          diffs;

        reset      = 1'b0;
        req_valid  = '0;
        req_write  = '0;
        req_half   = '0;
        req_signed = '0;
        for (int i = 0; i < 2; i++) begin
            req_addr[i]  = '0;
            req_wdata[i] = '0;
            for (int a = 0; a < 256; a++) set_byte(i, 8'(a), 8'($urandom));
        end
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 2; i++)
            check("reset_outs",
                  {mem_read[i], mem_write[i], mem_address[i], mem_write_data[i], resp_valid[i], misaligned[i], stall[i]},
                  32'd0);
        check("reset_ld0", 32'(load_data[0]), 32'd0);
        reset = 1'b1;
        @(negedge clock);

        set_byte(0, 8'd3, 8'h0B);
        set_byte(0, 8'd5, 8'h04);
        set_byte(0, 8'd6, 8'h88);
        set_byte(0, 8'd9, 8'hF0);
        @(negedge clock);
        access(0, 1'b0, 1'b0, 1'b0, 8'd3, 16'h0, got);
        check("ld_byte3", 32'(got), 32'h000B);
`ifndef MAU_ALIGN_CHECK_EN
        access(0, 1'b0, 1'b1, 1'b0, 8'd5, 16'h0, got);
        check("ld_half5", 32'(got), 32'h8804);
`endif
        access(0, 1'b0, 1'b0, 1'b1, 8'd9, 16'h0, got);
        check("ld_signed", 32'(got), 32'hFFF0);
        access(0, 1'b0, 1'b0, 1'b0, 8'd9, 16'h0, got);
        check("ld_unsigned", 32'(got), 32'h00F0);

        set_byte(0, 8'hFF, 8'h11);
        set_byte(0, 8'h00, 8'h22);
        @(negedge clock);
        access(0, 1'b1, 1'b1, 1'b0, 8'hFF, 16'hBEEF, got);
`ifdef MAU_ALIGN_CHECK_EN
        check("wrap_lo", 32'(mem[0][8'hFF]), 32'h11);
        check("wrap_hi", 32'(mem[0][8'h00]), 32'h22);
`else
        check("wrap_lo", 32'(mem[0][8'hFF]), 32'hEF);
        check("wrap_hi", 32'(mem[0][8'h00]), 32'hBE);
`endif

        access(1, 1'b0, 1'b1, 1'b0, 8'd0, 16'h0, got);
        check("ws2_half0", 32'(got), {16'd0, ref_mem[1][1], ref_mem[1][0]});

        // Reset during the high byte of a halfword store
        keep9 = ref_mem[0][9];
        req_write[0]  = 1'b1;
        req_half[0]   = 1'b1;
        req_signed[0] = 1'b0;
        req_addr[0]   = 8'd8;
        req_wdata[0]  = 16'h1234;
        req_valid[0]  = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_pre_wr", 32'(mem_write[0]), 32'd1);
        reset        = 1'b0;
        req_valid[0] = 1'b0;
        #1 check("rst_wr_off", {30'd0, mem_write[0], stall[0]}, 32'd0);
        @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        @(negedge clock);
        check("rst_idle", {29'd0, stall[0], resp_valid[0], mem_write[0]}, 32'd0);
        check("rst_mem8", 32'(mem[0][8]), 32'h34);
        check("rst_mem9", 32'(mem[0][9]), 32'(keep9));
        ref_mem[0][8] = 8'h34;

        for (int i = 0; i < 2; i++) begin
            for (int t = 0; t < 30; t++) begin
                access(i, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       (t % 10 == 0) ? 8'hFF : 8'($urandom), 16'($urandom), got);
            end
        end

        for (int i = 0; i < 2; i++) begin
            diffs = 0;
            for (int a = 0; a < 256; a++) if (mem[i][a] !== ref_mem[i][a]) diffs++;
            check("mem_image", 32'(diffs), 32'd0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
